// File: rtl/graph_dma_shim_pkg.sv
// Shared state encodings, direction constants and helpers for the graph-mode DMA shim.
package graph_dma_shim_pkg;

  localparam logic [2:0] DMA_IDLE    = 3'd0;
  localparam logic [2:0] DMA_LD_REQ  = 3'd1;
  localparam logic [2:0] DMA_LD_WAIT = 3'd2;
  localparam logic [2:0] DMA_ST_RD   = 3'd3;
  localparam logic [2:0] DMA_ST_RDW  = 3'd4;
  localparam logic [2:0] DMA_ST_WR   = 3'd5;
  localparam logic [2:0] DMA_NXT     = 3'd6;
  localparam logic [2:0] DMA_DONE    = 3'd7;

  localparam logic DMA_DIR_LOAD  = 1'b0;
  localparam logic DMA_DIR_STORE = 1'b1;

  // First state of each byte transfer for the given direction.
  function automatic logic [2:0] dma_resume_state(input logic dir);
    return (dir == DMA_DIR_STORE) ? DMA_ST_RD : DMA_LD_REQ;
  endfunction

endpackage

// File: rtl/graph_dma_shim_if.sv
// Command, DDR byte port and SRAM0 DMA port bundle; slave is the shim, master is its environment.
interface graph_dma_shim_if #(
  parameter int SRAM0_AW = 16,
  parameter int DDR_AW   = 32
);
  logic                dma_cmd_valid;
  logic [31:0]         dma_ddr_addr;
  logic [15:0]         dma_sram_addr;
  logic [15:0]         dma_length;
  logic                dma_direction;
  logic                dma_strided;
  logic [31:0]         dma_stride;
  logic [15:0]         dma_count;
  logic [15:0]         dma_block_len;
  logic                dma_done;
  logic                dma_busy;
  logic                ddr_rd_req;
  logic [DDR_AW-1:0]   ddr_rd_addr;
  logic                ddr_rd_valid;
  logic [7:0]          ddr_rd_data;
  logic                ddr_wr_req;
  logic [DDR_AW-1:0]   ddr_wr_addr;
  logic [7:0]          ddr_wr_data;
  logic                ddr_wr_ack;
  logic                sram_wr_en;
  logic [SRAM0_AW-1:0] sram_wr_addr;
  logic [7:0]          sram_wr_data;
  logic                sram_rd_en;
  logic [SRAM0_AW-1:0] sram_rd_addr;
  logic [7:0]          sram_rd_data;
  logic                cmd_drop;
  logic [31:0]         perf_bytes;

  modport slave (
    input  dma_cmd_valid, dma_ddr_addr, dma_sram_addr, dma_length, dma_direction,
           dma_strided, dma_stride, dma_count, dma_block_len,
           ddr_rd_valid, ddr_rd_data, ddr_wr_ack, sram_rd_data,
    output dma_done, dma_busy, ddr_rd_req, ddr_rd_addr, ddr_wr_req, ddr_wr_addr,
           ddr_wr_data, sram_wr_en, sram_wr_addr, sram_wr_data, sram_rd_en,
           sram_rd_addr, cmd_drop, perf_bytes
  );

  modport master (
    output dma_cmd_valid, dma_ddr_addr, dma_sram_addr, dma_length, dma_direction,
           dma_strided, dma_stride, dma_count, dma_block_len,
           ddr_rd_valid, ddr_rd_data, ddr_wr_ack, sram_rd_data,
    input  dma_done, dma_busy, ddr_rd_req, ddr_rd_addr, ddr_wr_req, ddr_wr_addr,
           ddr_wr_data, sram_wr_en, sram_wr_addr, sram_wr_data, sram_rd_en,
           sram_rd_addr, cmd_drop, perf_bytes
  );
endinterface

// File: rtl/graph_dma_shim.sv
// Graph-mode DMA responder: byte mover between DDR and SRAM0, contiguous or strided.
//   state   | meaning
//   IDLE    | waiting for dma_cmd_valid
//   LD_REQ  | one-cycle DDR read request at d_ptr
//   LD_WAIT | waiting for ddr_rd_valid; SRAM write issued next cycle
//   ST_RD   | SRAM0 read strobe at s_ptr
//   ST_RDW  | SRAM0 read data captured
//   ST_WR   | DDR write request held until ack
//   NXT     | step to next block start (blk_base += stride)
//   DONE    | one-cycle dma_done
module graph_dma_shim
  import graph_dma_shim_pkg::*;
#(
  parameter int SRAM0_AW = 16,
  parameter int DDR_AW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  graph_dma_shim_if.slave bus
);

  logic [2:0]          state;
  logic                dir;
  logic [15:0]         blocks, blen, byte_cnt, blk_cnt;
  logic [DDR_AW-1:0]   blk_base, d_ptr, stride;
  logic [SRAM0_AW-1:0] s_ptr;
  logic [7:0]          wr_data_q;
  logic                sram_wr_en_q;
  logic [SRAM0_AW-1:0] sram_wr_addr_q;
  logic [7:0]          sram_wr_data_q;
  logic                cmd_drop_q;
  logic [31:0]         perf_q;

  logic [15:0]         cmd_blocks, cmd_blen;
  logic                byte_step, byte_last, blk_last;
  logic [DDR_AW-1:0]   next_base;

  assign cmd_blocks = bus.dma_strided ? bus.dma_count : 16'd1;
  assign cmd_blen   = bus.dma_strided ? bus.dma_block_len : bus.dma_length;
  assign byte_step  = ((state == DMA_LD_WAIT) && bus.ddr_rd_valid) ||
                      ((state == DMA_ST_WR) && bus.ddr_wr_ack);
  assign byte_last  = (byte_cnt + 16'd1) == blen;
  assign blk_last   = (blk_cnt + 16'd1) == blocks;
  assign next_base  = blk_base + stride;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= DMA_IDLE;
      dir            <= DMA_DIR_LOAD;
      blocks         <= '0;
      blen           <= '0;
      byte_cnt       <= '0;
      blk_cnt        <= '0;
      blk_base       <= '0;
      d_ptr          <= '0;
      stride         <= '0;
      s_ptr          <= '0;
      wr_data_q      <= '0;
      sram_wr_en_q   <= 1'b0;
      sram_wr_addr_q <= '0;
      sram_wr_data_q <= '0;
      cmd_drop_q     <= 1'b0;
      perf_q         <= '0;
    end else begin
      sram_wr_en_q <= 1'b0;
      if (bus.dma_cmd_valid && (state != DMA_IDLE))
        cmd_drop_q <= 1'b1;

      if (byte_step) begin
        s_ptr    <= s_ptr + SRAM0_AW'(1);
        d_ptr    <= d_ptr + DDR_AW'(1);
        byte_cnt <= byte_cnt + 16'd1;
        perf_q   <= perf_q + 32'd1;
        if (byte_last)
          blk_cnt <= blk_cnt + 16'd1;
      end

      case (state)
        DMA_IDLE: if (bus.dma_cmd_valid) begin
          dir      <= bus.dma_direction;
          blocks   <= cmd_blocks;
          blen     <= cmd_blen;
          stride   <= bus.dma_stride[DDR_AW-1:0];
          blk_base <= bus.dma_ddr_addr[DDR_AW-1:0];
          d_ptr    <= bus.dma_ddr_addr[DDR_AW-1:0];
          s_ptr    <= bus.dma_sram_addr[SRAM0_AW-1:0];
          byte_cnt <= '0;
          blk_cnt  <= '0;
          state    <= ((cmd_blocks == 16'd0) || (cmd_blen == 16'd0))
                      ? DMA_DONE : dma_resume_state(bus.dma_direction);
        end
        DMA_LD_REQ: state <= DMA_LD_WAIT;
        DMA_ST_RD:  state <= DMA_ST_RDW;
        DMA_ST_RDW: begin
          wr_data_q <= bus.sram_rd_data;
          state     <= DMA_ST_WR;
        end
        DMA_LD_WAIT, DMA_ST_WR: if (byte_step) begin
          if (state == DMA_LD_WAIT) begin
            sram_wr_en_q   <= 1'b1;
            sram_wr_addr_q <= s_ptr;
            sram_wr_data_q <= bus.ddr_rd_data;
          end
          // The last block goes straight to DONE so dma_done follows the final byte.
          state <= byte_last ? (blk_last ? DMA_DONE : DMA_NXT) : dma_resume_state(dir);
        end
        DMA_NXT: begin
          blk_base <= next_base;
          d_ptr    <= next_base;
          byte_cnt <= '0;
          state    <= dma_resume_state(dir);
        end
        default: state <= DMA_IDLE;
      endcase
    end
  end

  assign bus.dma_done     = (state == DMA_DONE);
  assign bus.dma_busy     = (state != DMA_IDLE) && (state != DMA_DONE);
  assign bus.ddr_rd_req   = (state == DMA_LD_REQ);
  assign bus.ddr_rd_addr  = d_ptr;
  assign bus.ddr_wr_req   = (state == DMA_ST_WR);
  assign bus.ddr_wr_addr  = d_ptr;
  assign bus.ddr_wr_data  = wr_data_q;
  assign bus.sram_wr_en   = sram_wr_en_q;
  assign bus.sram_wr_addr = sram_wr_addr_q;
  assign bus.sram_wr_data = sram_wr_data_q;
  assign bus.sram_rd_en   = (state == DMA_ST_RD);
  assign bus.sram_rd_addr = s_ptr;
  assign bus.cmd_drop     = cmd_drop_q;
  assign bus.perf_bytes   = perf_q;

endmodule

// File: tb/tb_graph_dma_shim.sv
// Directed bench for graph_dma_shim with DDR/SRAM0 byte models and a vector table.
module tb_graph_dma_shim;
  import graph_dma_shim_pkg::*;

  localparam int RD_LAT = 2;

  typedef struct {
    logic [31:0] ddr;
    logic [15:0] sram;
    logic [15:0] len;
    logic        dir;
    logic        strided;
    logic [31:0] stride;
    logic [15:0] count;
    logic [15:0] blen;
    int          exp_cyc;
    int          exp_rd;
    int          exp_ack;
    int          exp_swr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  graph_dma_shim_if #(.SRAM0_AW(16), .DDR_AW(32)) bus ();

  graph_dma_shim #(.SRAM0_AW(16), .DDR_AW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]  ddr_mem  [4096];
  logic [7:0]  sram_mem [256];
  int          rd_cd;
  logic [11:0] rd_a;
  int          ack_wait, ack_idx;
  int          ack_dly [3] = '{0, 1, 3};
  int          cnt_rd = 0, cnt_ack = 0, cnt_swr = 0, cnt_sre = 0, cnt_done = 0;
  int          n_checks = 0, n_fail = 0;

  function automatic logic [7:0] dpat(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], 4'h3};
  endfunction

  function automatic logic [7:0] spat(input logic [7:0] a);
    return ~a ^ 8'h3C;
  endfunction

  assign bus.ddr_wr_ack = bus.ddr_wr_req && (ack_wait == ack_dly[ack_idx % 3]);

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_cd            <= 0;
      rd_a             <= '0;
      ack_wait         <= 0;
      ack_idx          <= 0;
      bus.ddr_rd_valid <= 1'b0;
      bus.ddr_rd_data  <= '0;
      bus.sram_rd_data <= '0;
      for (int i = 0; i < 4096; i++) ddr_mem[i] <= dpat(12'(i));
      for (int i = 0; i < 256; i++)  sram_mem[i] <= spat(8'(i));
    end else begin
      bus.ddr_rd_valid <= 1'b0;
      if (bus.ddr_rd_req) begin
        rd_a <= bus.ddr_rd_addr[11:0];
        if (RD_LAT <= 1) begin
          bus.ddr_rd_valid <= 1'b1;
          bus.ddr_rd_data  <= ddr_mem[bus.ddr_rd_addr[11:0]];
        end else begin
          rd_cd <= RD_LAT - 1;
        end
      end else if (rd_cd > 0) begin
        rd_cd <= rd_cd - 1;
        if (rd_cd == 1) begin
          bus.ddr_rd_valid <= 1'b1;
          bus.ddr_rd_data  <= ddr_mem[rd_a];
        end
      end
      if (bus.sram_wr_en) sram_mem[bus.sram_wr_addr[7:0]] <= bus.sram_wr_data;
      if (bus.sram_rd_en) bus.sram_rd_data <= sram_mem[bus.sram_rd_addr[7:0]];
      if (bus.ddr_wr_req) begin
        if (bus.ddr_wr_ack) begin
          ddr_mem[bus.ddr_wr_addr[11:0]] <= bus.ddr_wr_data;
          ack_wait <= 0;
          ack_idx  <= ack_idx + 1;
        end else begin
          ack_wait <= ack_wait + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    cnt_rd   <= cnt_rd   + int'(bus.ddr_rd_req);
    cnt_ack  <= cnt_ack  + int'(bus.ddr_wr_req && bus.ddr_wr_ack);
    cnt_swr  <= cnt_swr  + int'(bus.sram_wr_en);
    cnt_sre  <= cnt_sre  + int'(bus.sram_rd_en);
    cnt_done <= cnt_done + int'(bus.dma_done);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    bus.dma_ddr_addr  = v.ddr;
    bus.dma_sram_addr = v.sram;
    bus.dma_length    = v.len;
    bus.dma_direction = v.dir;
    bus.dma_strided   = v.strided;
    bus.dma_stride    = v.stride;
    bus.dma_count     = v.count;
    bus.dma_block_len = v.blen;
    bus.dma_cmd_valid = 1'b1;
  endtask

  task automatic wait_done(inout int cyc);
    while (!bus.dma_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.dma_done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("busy_low_in_done", bus.dma_busy, 0);
      @(negedge clk);
      chk("done_single_cycle", bus.dma_done, 0);
    end
  endtask

  task automatic check_mem(input vec_t v, input int idx);
    int nb, bl;
    logic [31:0] d;
    logic [15:0] s;
    nb = v.strided ? int'(v.count) : 1;
    bl = v.strided ? int'(v.blen) : int'(v.len);
    for (int k = 0; k < nb; k++)
      for (int j = 0; j < bl; j++) begin
        s = v.sram + 16'(k * bl + j);
        d = v.ddr + 32'(k) * v.stride + 32'(j);
        if (v.dir == DMA_DIR_LOAD)
          chk($sformatf("v%0d_sram[%0h]", idx, s), sram_mem[s[7:0]], dpat(d[11:0]));
        else
          chk($sformatf("v%0d_ddr[%0h]", idx, d), ddr_mem[d[11:0]], spat(s[7:0]));
      end
  endtask

  vec_t vecs [6];
  vec_t v;

  initial begin
    int cyc, b_rd, b_ack, b_swr, b_sre, b_done;
    logic [31:0] b_perf;

    vecs[0] = '{ddr:32'h100, sram:16'h20, len:16'd4, dir:DMA_DIR_LOAD, strided:1'b0, stride:32'd0,
                count:16'd0, blen:16'd0, exp_cyc:13, exp_rd:4, exp_ack:0, exp_swr:4};
    vecs[1] = '{ddr:32'h40, sram:16'h0, len:16'd0, dir:DMA_DIR_LOAD, strided:1'b1, stride:32'd16,
                count:16'd3, blen:16'd2, exp_cyc:21, exp_rd:6, exp_ack:0, exp_swr:6};
    vecs[2] = '{ddr:32'h200, sram:16'h10, len:16'd3, dir:DMA_DIR_STORE, strided:1'b0, stride:32'd0,
                count:16'd0, blen:16'd0, exp_cyc:14, exp_rd:0, exp_ack:3, exp_swr:0};
    vecs[3] = '{ddr:32'h100, sram:16'h30, len:16'd0, dir:DMA_DIR_LOAD, strided:1'b0, stride:32'd0,
                count:16'd0, blen:16'd0, exp_cyc:1, exp_rd:0, exp_ack:0, exp_swr:0};
    vecs[4] = '{ddr:32'h280, sram:16'h50, len:16'd7, dir:DMA_DIR_STORE, strided:1'b1, stride:32'd8,
                count:16'd0, blen:16'd5, exp_cyc:1, exp_rd:0, exp_ack:0, exp_swr:0};
    vecs[5] = '{ddr:32'h300, sram:16'h40, len:16'd0, dir:DMA_DIR_STORE, strided:1'b1, stride:32'h20,
                count:16'd2, blen:16'd1, exp_cyc:9, exp_rd:0, exp_ack:2, exp_swr:0};

    bus.dma_cmd_valid = 1'b0;
    bus.dma_ddr_addr  = '0;
    bus.dma_sram_addr = '0;
    bus.dma_length    = '0;
    bus.dma_direction = 1'b0;
    bus.dma_strided   = 1'b0;
    bus.dma_stride    = '0;
    bus.dma_count     = '0;
    bus.dma_block_len = '0;

    repeat (3) @(negedge clk);
    chk("rst_done", bus.dma_done, 0);
    chk("rst_busy", bus.dma_busy, 0);
    chk("rst_rd_req", bus.ddr_rd_req, 0);
    chk("rst_wr_req", bus.ddr_wr_req, 0);
    chk("rst_sram_wr_en", bus.sram_wr_en, 0);
    chk("rst_sram_rd_en", bus.sram_rd_en, 0);
    chk("rst_cmd_drop", bus.cmd_drop, 0);
    chk("rst_perf", bus.perf_bytes, 0);
    chk("rst_rd_addr", bus.ddr_rd_addr, 0);
    chk("rst_wr_data", bus.ddr_wr_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      b_rd = cnt_rd; b_ack = cnt_ack; b_swr = cnt_swr; b_sre = cnt_sre;
      b_done = cnt_done; b_perf = bus.perf_bytes;
      drive_cmd(vecs[i]);
      @(negedge clk);
      bus.dma_cmd_valid = 1'b0;
      cyc = 1;
      wait_done(cyc);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
      chk($sformatf("v%0d_rd_reqs", i), cnt_rd - b_rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_wr_acks", i), cnt_ack - b_ack, vecs[i].exp_ack);
      chk($sformatf("v%0d_sram_wr", i), cnt_swr - b_swr, vecs[i].exp_swr);
      chk($sformatf("v%0d_sram_rd", i), cnt_sre - b_sre, vecs[i].exp_ack);
      chk($sformatf("v%0d_done_cnt", i), cnt_done - b_done, 1);
      chk($sformatf("v%0d_perf", i), bus.perf_bytes - b_perf, vecs[i].exp_swr + vecs[i].exp_ack);
      check_mem(vecs[i], i);
    end
    chk("no_drop_yet", bus.cmd_drop, 0);

    // Command arriving mid-transfer must be dropped without disturbing the active one.
    v = '{ddr:32'h500, sram:16'h80, len:16'd3, dir:DMA_DIR_LOAD, strided:1'b0, stride:32'd0,
          count:16'd0, blen:16'd0, exp_cyc:10, exp_rd:3, exp_ack:0, exp_swr:3};
    b_rd = cnt_rd; b_ack = cnt_ack; b_swr = cnt_swr; b_sre = cnt_sre;
    b_done = cnt_done; b_perf = bus.perf_bytes;
    drive_cmd(v);
    @(negedge clk);
    bus.dma_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    drive_cmd('{ddr:32'h900, sram:16'h10, len:16'd2, dir:DMA_DIR_STORE, strided:1'b0, stride:32'd0,
                count:16'd0, blen:16'd0, exp_cyc:0, exp_rd:0, exp_ack:0, exp_swr:0});
    @(negedge clk);
    bus.dma_cmd_valid = 1'b0;
    chk("drop_sticky", bus.cmd_drop, 1);
    cyc = 4;
    wait_done(cyc);
    chk("drop_cycles", cyc, v.exp_cyc);
    chk("drop_rd_reqs", cnt_rd - b_rd, 3);
    chk("drop_wr_acks", cnt_ack - b_ack, 0);
    chk("drop_sram_rd", cnt_sre - b_sre, 0);
    chk("drop_sram_wr", cnt_swr - b_swr, 3);
    chk("drop_done_cnt", cnt_done - b_done, 1);
    chk("drop_perf", bus.perf_bytes - b_perf, 3);
    chk("drop_still_set", bus.cmd_drop, 1);
    check_mem(v, 6);

    // Asynchronous reset in the middle of a load.
    b_done = cnt_done;
    drive_cmd('{ddr:32'h600, sram:16'h90, len:16'd4, dir:DMA_DIR_LOAD, strided:1'b0, stride:32'd0,
                count:16'd0, blen:16'd0, exp_cyc:0, exp_rd:0, exp_ack:0, exp_swr:0});
    @(negedge clk);
    bus.dma_cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", bus.dma_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.dma_busy, 0);
    chk("arst_done", bus.dma_done, 0);
    chk("arst_rd_req", bus.ddr_rd_req, 0);
    chk("arst_sram_wr_en", bus.sram_wr_en, 0);
    chk("arst_perf", bus.perf_bytes, 0);
    chk("arst_cmd_drop", bus.cmd_drop, 0);
    repeat (3) @(negedge clk);
    chk("arst_no_done", cnt_done - b_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    v = '{ddr:32'h700, sram:16'hA0, len:16'd2, dir:DMA_DIR_LOAD, strided:1'b0, stride:32'd0,
          count:16'd0, blen:16'd0, exp_cyc:7, exp_rd:2, exp_ack:0, exp_swr:2};
    b_rd = cnt_rd; b_done = cnt_done;
    drive_cmd(v);
    @(negedge clk);
    bus.dma_cmd_valid = 1'b0;
    cyc = 1;
    wait_done(cyc);
    chk("post_rst_cycles", cyc, v.exp_cyc);
    chk("post_rst_rd_reqs", cnt_rd - b_rd, 2);
    chk("post_rst_done_cnt", cnt_done - b_done, 1);
    chk("post_rst_perf", bus.perf_bytes, 2);
    check_mem(v, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
